pipeline_ctrl: RTL
==================

# pipeline_ctrl

Pipeline control unit that drives the register-control side (`EN`, `flush`) of all four pipeline latches (fetch/decode, decode/execute, execute/memory, memory/writeback) plus the PC write enable. It resolves memory wait states, load-use hazards, instruction-fetch misses, taken branches/jumps and halt. It sits beside the datapath in the pipelined CPU, consuming hazard status from the latches' outputs and cache hit signals. Its Mealy control outputs are decided combinationally each cycle from the current state and inputs, and a registered state machine sequences halt and the optional performance counters.

## Interface
- No parameters.
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous active-low reset.
- `ihit` in 1: instruction fetch completes this cycle.
- `dhit` in 1: data access completes this cycle.
- `dec_rs`, `dec_rt` in 5 each: source registers of the instruction in decode.
- `dec_uses_rt` in 1: decode instruction reads `rt` as a source.
- `exe_MemRd` in 1: instruction in execute is a load.
- `exe_rt` in 5: destination of that load.
- `mem_MemRd`, `mem_MemWr` in 1 each: memory-stage access pending.
- `mem_take` in 1: branch taken or jump resolved in the memory stage.
- `mem_halt` in 1: halt instruction in the memory stage.
- `pc_EN` out 1: PC write enable.
- `fd_EN`, `de_EN`, `em_EN`, `mw_EN` out 1 each: latch enables.
- `fd_flush`, `de_flush`, `em_flush`, `mw_flush` out 1 each: latch flushes. A flush is honoured only when the same latch's EN is 1, and loads zeros.
- `halt` out 1: registered; CPU halted.
- `stall_cnt` out 32: stall-cycle counter.
- `flush_cnt` out 32: redirect counter.

## Operation
- States: RUN, DRAIN, HALTED. Reset state is RUN.
- While `nRST`=0, every output is 0.
- Derived signals:
  - mem_busy = (`mem_MemRd`|`mem_MemWr`) & ~`dhit`.
  - load_use = `exe_MemRd` & `exe_rt`≠0 & (`exe_rt`==`dec_rs` | (`dec_uses_rt` & `exe_rt`==`dec_rt`)).
- Default in RUN: all EN=1, all flush=0, `pc_EN`=1.
- RUN rules in strict priority; the first match wins.
  1. mem_busy: `pc_EN`, `fd_EN`, `de_EN`, `em_EN` = 0; `mw_EN`=1 with `mw_flush`=1, which inserts a WB bubble.
  2. `mem_halt`: `pc_EN`=0; `fd_flush`, `de_flush`, `em_flush`=1; `mw` advances. Next state DRAIN.
  3. `mem_take`: `pc_EN`=1 regardless of `ihit`, so the in-flight fetch is abandoned; `fd_flush`, `de_flush`, `em_flush`=1; `mw` advances.
  4. load_use: `pc_EN`=0, `fd_EN`=0, `de_flush`=1; `em` and `mw` advance.
  5. ~`ihit`: `pc_EN`=0, `fd_flush`=1; the remaining latches advance.
- DRAIN: `mw_EN`=1, all other EN=0, `pc_EN`=0. Next state HALTED unconditionally.
- HALTED: all EN, flush and `pc_EN` = 0; `halt`=1. Only `nRST` leaves HALTED.
- `halt` is registered. It is 1 exactly when the state is HALTED.
- `mem_take` and `mem_halt` together: halt wins.
- load_use and ~`ihit` together: load_use wins.
- `exe_rt`=0 never triggers load_use.

## Timing
- All EN and flush outputs and `pc_EN` are combinational from the current state and same-cycle inputs; no added latency.
- If `mem_halt` is accepted in cycle N: the state is DRAIN in N+1, HALTED in N+2, and `halt`=1 from N+2.
- Asserting `nRST` in any state asynchronously forces RUN, `halt`=0, counters=0 and all outputs 0. The first edge after deassertion operates in RUN.
- Counters update on the rising `CLK` edge. They are visible the cycle after the counted event.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `stall_cnt` increments each RUN cycle with `pc_EN`=0 whose cause is rule 1, 4 or 5.
  - `flush_cnt` increments each cycle rule 3 fires.
  - Both saturate at 32'hFFFFFFFF and hold in DRAIN and HALTED.
- Not defined: no counter registers exist; `stall_cnt` and `flush_cnt` are tied to 0.

## Test plan
- Reset held, then released with `ihit`=1 and no hazards -> all EN=1, flushes=0, `pc_EN`=1, `halt`=0.
- `exe_MemRd`=1, `exe_rt`=5, `dec_rs`=5 for one cycle -> `pc_EN`=0, `fd_EN`=0, `de_flush`=1, `em_EN`=`mw_EN`=1. Repeating with `exe_rt`=0 -> no stall.
- `mem_MemRd`=1 with `dhit`=0 for 3 cycles, then `dhit`=1 -> 3 cycles of freeze with `mw_flush`=1, then normal. With macro defined, `stall_cnt`=3.
- `mem_take`=1 with `ihit`=0 -> `pc_EN`=1; `fd_flush`, `de_flush`, `em_flush`=1. With macro defined, `flush_cnt` increments by 1.
- `mem_halt`=1 and `mem_take`=1 in cycle N -> halt path taken; state DRAIN in N+1 with only `mw_EN`=1; `halt`=1 from N+2 onward; all EN=0 while halted.
- `nRST` pulsed low while HALTED -> `halt`=0 immediately and counters=0. With the macro undefined, counters read 0 throughout every scenario.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard status and latch control bundle between datapath and pipeline_ctrl
interface pipeline_ctrl_if;
    logic        ihit;
    logic        dhit;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic        dec_uses_rt;
    logic        exe_MemRd;
    logic [4:0]  exe_rt;
    logic        mem_MemRd;
    logic        mem_MemWr;
    logic        mem_take;
    logic        mem_halt;
    logic        pc_EN;
    logic        fd_EN;
    logic        de_EN;
    logic        em_EN;
    logic        mw_EN;
    logic        fd_flush;
    logic        de_flush;
    logic        em_flush;
    logic        mw_flush;
    logic        halt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output ihit, dhit, dec_rs, dec_rt, dec_uses_rt, exe_MemRd, exe_rt,
               mem_MemRd, mem_MemWr, mem_take, mem_halt,
        input  pc_EN, fd_EN, de_EN, em_EN, mw_EN,
               fd_flush, de_flush, em_flush, mw_flush, halt, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, dec_rs, dec_rt, dec_uses_rt, exe_MemRd, exe_rt,
               mem_MemRd, mem_MemWr, mem_take, mem_halt,
        output pc_EN, fd_EN, de_EN, em_EN, mw_EN,
               fd_flush, de_flush, em_flush, mw_flush, halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline latch enable/flush control with halt sequencing
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl (
    input  logic             CLK,
    input  logic             nRST,
    pipeline_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

    state_t state;
    logic   halt_q;
    logic   mem_busy, load_use;
    logic   pc_en, fd_en, de_en, em_en, mw_en;
    logic   fd_fl, de_fl, em_fl, mw_fl;
    logic   stall_ev, flush_ev, halt_req;

    assign mem_busy = (bus.mem_MemRd | bus.mem_MemWr) & ~bus.dhit;
    assign load_use = bus.exe_MemRd & (bus.exe_rt != 5'd0) &
                      ((bus.exe_rt == bus.dec_rs) |
                       (bus.dec_uses_rt & (bus.exe_rt == bus.dec_rt)));

    // Everything is forced low while reset is asserted, independent of the clock.
    always_comb begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        de_en    = 1'b0;
        em_en    = 1'b0;
        mw_en    = 1'b0;
        fd_fl    = 1'b0;
        de_fl    = 1'b0;
        em_fl    = 1'b0;
        mw_fl    = 1'b0;
        stall_ev = 1'b0;
        flush_ev = 1'b0;
        halt_req = 1'b0;
        if (nRST) begin
            case (state)
                RUN: begin
                    pc_en = 1'b1;
                    fd_en = 1'b1;
                    de_en = 1'b1;
                    em_en = 1'b1;
                    mw_en = 1'b1;
                    if (mem_busy) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_en    = 1'b0;
                        em_en    = 1'b0;
                        mw_fl    = 1'b1;
                        stall_ev = 1'b1;
                    end else if (bus.mem_halt) begin
                        pc_en    = 1'b0;
                        fd_fl    = 1'b1;
                        de_fl    = 1'b1;
                        em_fl    = 1'b1;
                        halt_req = 1'b1;
                    end else if (bus.mem_take) begin
                        fd_fl    = 1'b1;
                        de_fl    = 1'b1;
                        em_fl    = 1'b1;
                        flush_ev = 1'b1;
                    end else if (load_use) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_fl    = 1'b1;
                        stall_ev = 1'b1;
                    end else if (!bus.ihit) begin
                        pc_en    = 1'b0;
                        fd_fl    = 1'b1;
                        stall_ev = 1'b1;
                    end
                end
                DRAIN:   mw_en = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= RUN;
            halt_q <= 1'b0;
        end else begin
            case (state)
                RUN: if (halt_req) state <= DRAIN;
                DRAIN: begin
                    state  <= HALTED;
                    halt_q <= 1'b1;
                end
                default: begin
                    state  <= HALTED;
                    halt_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (stall_ev && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
            if (flush_ev && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.stall_cnt = 32'd0;
    assign bus.flush_cnt = 32'd0;
`endif

    assign bus.pc_EN    = pc_en;
    assign bus.fd_EN    = fd_en;
    assign bus.de_EN    = de_en;
    assign bus.em_EN    = em_en;
    assign bus.mw_EN    = mw_en;
    assign bus.fd_flush = fd_fl;
    assign bus.de_flush = de_fl;
    assign bus.em_flush = em_fl;
    assign bus.mw_flush = mw_fl;
    assign bus.halt     = halt_q;
endmodule
